// File: rtl/mnist_frame_sender.sv
// mnist_frame_sender
// Streams one image (NPIX 8-bit pixels) onto the accelerator's 17-bit pad bus.
// Each pixel is one beat, and GAP idle cycles follow every beat. The block then
// waits for a rising edge on the accelerator's done flag and captures the digit
// it reports. If no edge arrives within TIMEOUT cycles, it raises a sticky error.

module mnist_frame_sender #(
    parameter int NPIX    = 784,
    parameter int GAP     = 1,
    parameter int TIMEOUT = 4096
) (
    input  logic        clk,
    input  logic        wb_rst_i,
    input  logic        start,
    input  logic        pix_valid,
    input  logic [7:0]  pix_data,
    output logic        pix_ready,
    output logic [16:0] acc_bus,
    input  logic [3:0]  acc_digit,
    input  logic        acc_done,
    output logic [3:0]  result_digit,
    output logic        result_valid,
    output logic        busy,
    output logic        timeout_err
);

    localparam int PW = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [PW-1:0] LAST_PIX = PW'(NPIX - 1);
    localparam logic [GW-1:0] GAP_LOAD = GW'(GAP);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT
    } state_t;

    state_t state;
    state_t next_state;

    logic [PW-1:0] pix_cnt;
    logic [GW-1:0] gap_cnt;
    logic [TW-1:0] to_cnt;

    logic done_sync1;
    logic done_sync2;
    logic done_prev;
    logic done_rise;

    logic beat;
    logic accept_start;
    logic last_beat;
    logic capture;
    logic expire;

    // A rising edge is only real once the pad level has cleared both synchroniser flops.
    assign done_rise = done_sync2 & ~done_prev;

    // Ready is withheld while the inter-beat gap is still counting down.
    assign pix_ready = (state == ST_SEND) && (gap_cnt == '0);
    assign beat      = pix_valid & pix_ready;

    // State register.
    always_ff @(posedge clk or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode. The done edge is tested before the timeout, so the done edge wins a tie.
    always_comb begin
        next_state   = state;
        accept_start = 1'b0;
        last_beat    = 1'b0;
        capture      = 1'b0;
        expire       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    accept_start = 1'b1;
                    next_state   = ST_SEND;
                end
            end
            ST_SEND: begin
                if (beat && (pix_cnt == LAST_PIX)) begin
                    last_beat  = 1'b1;
                    next_state = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (done_rise) begin
                    capture    = 1'b1;
                    next_state = ST_IDLE;
                end else if (to_cnt == TO_LAST) begin
                    expire     = 1'b1;
                    next_state = ST_IDLE;
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // Two-flop synchroniser for the asynchronous done pad, plus the edge-detect history flop.
    always_ff @(posedge clk or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            done_sync1 <= 1'b0;
            done_sync2 <= 1'b0;
            done_prev  <= 1'b0;
        end else begin
            done_sync1 <= acc_done;
            done_sync2 <= done_sync1;
            done_prev  <= done_sync2;
        end
    end

    // Pixel index and gap pacing. The gap reloads after every beat and then drains to zero.
    always_ff @(posedge clk or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            pix_cnt <= '0;
            gap_cnt <= '0;
        end else if (accept_start) begin
            pix_cnt <= '0;
            gap_cnt <= '0;
        end else if (beat) begin
            pix_cnt <= last_beat ? '0 : pix_cnt + PW'(1);
            gap_cnt <= GAP_LOAD;
        end else if (gap_cnt != '0) begin
            gap_cnt <= gap_cnt - GW'(1);
        end
    end

    // Counts cycles spent waiting for the accelerator, starting from zero on entry to WAIT.
    always_ff @(posedge clk or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            to_cnt <= '0;
        end else if (last_beat) begin
            to_cnt <= '0;
        end else if (state == ST_WAIT) begin
            to_cnt <= to_cnt + TW'(1);
        end
    end

    // Registered pad bus. It carries a word only in the cycle after a beat and returns to zero otherwise.
    always_ff @(posedge clk or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            acc_bus <= '0;
        end else if (beat) begin
            acc_bus <= {(pix_cnt == '0), 1'b1, 7'b0, pix_data};
        end else begin
            acc_bus <= '0;
        end
    end

    // Status outputs: busy tracks the next state, the result is latched on capture, and the error is sticky until the next start.
    always_ff @(posedge clk or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            busy         <= 1'b0;
            result_valid <= 1'b0;
            result_digit <= '0;
            timeout_err  <= 1'b0;
        end else begin
            busy         <= (next_state != ST_IDLE);
            result_valid <= capture;
            if (capture) begin
                result_digit <= acc_digit;
            end
            if (accept_start) begin
                timeout_err <= 1'b0;
            end else if (expire) begin
                timeout_err <= 1'b1;
            end
        end
    end

endmodule
